// File: rtl/q3b_ctx_scheduler.sv
// rtl/q3b_ctx_scheduler.sv - round-robin time-shared A..E bit-serial detector over N_CH channel contexts
// Optional feature macro: Q3B_CTX_CLR_EN (adds ch_clr per-channel synchronous context clear)
module q3b_ctx_scheduler #(
  parameter int N_CH = 4,
  parameter int ID_W = $clog2(N_CH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] req,
  input  logic [N_CH-1:0] x,
`ifdef Q3B_CTX_CLR_EN
  input  logic [N_CH-1:0] ch_clr,
`endif
  output logic [N_CH-1:0] gnt,
  output logic            z_vld,
  output logic [ID_W-1:0] z_ch,
  output logic            z,
  output logic [N_CH-1:0] z_vec
);

  localparam logic [2:0] CTX_A = 3'd0;
  localparam logic [2:0] CTX_B = 3'd1;
  localparam logic [2:0] CTX_C = 3'd2;
  localparam logic [2:0] CTX_D = 3'd3;
  localparam logic [2:0] CTX_E = 3'd4;
  localparam logic [ID_W-1:0] LAST_CH = ID_W'(N_CH - 1);

  // Detector step; unreachable codes fall back to A so a corrupted context self-heals
  function automatic logic [2:0] ctx_next(input logic [2:0] c, input logic b);
    case (c)
      CTX_A:   ctx_next = b ? CTX_B : CTX_A;
      CTX_B:   ctx_next = b ? CTX_E : CTX_B;
      CTX_C:   ctx_next = b ? CTX_B : CTX_C;
      CTX_D:   ctx_next = b ? CTX_C : CTX_B;
      CTX_E:   ctx_next = b ? CTX_E : CTX_D;
      default: ctx_next = CTX_A;
    endcase
  endfunction

  function automatic logic ctx_out(input logic [2:0] c);
    ctx_out = (c == CTX_D) || (c == CTX_E);
  endfunction

  logic [2:0]      ctx [N_CH];
  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] ptr_nxt;
  logic [ID_W-1:0] win;
  logic [ID_W-1:0] idx_w;
  logic            found;
  logic [N_CH-1:0] elig;
  logic [2:0]      ctx_upd;
  int              idx;

  // Round-robin search starting at ptr over the eligible requesters; first hit wins
  always_comb begin
`ifdef Q3B_CTX_CLR_EN
    elig = req & ~ch_clr;
`else
    elig = req;
`endif
    win   = '0;
    found = 1'b0;
    idx   = 0;
    idx_w = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      idx_w = ID_W'(idx);
      if (!found && elig[idx_w]) begin
        found = 1'b1;
        win   = idx_w;
      end
    end
    gnt = '0;
    if (found) gnt[win] = 1'b1;
    ptr_nxt = (win == LAST_CH) ? '0 : win + 1'b1;
  end

  assign ctx_upd = ctx_next(ctx[win], x[win]);

  // Context store, rr pointer and registered result publication
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) ctx[i] <= CTX_A;
      ptr   <= '0;
      z_vld <= 1'b0;
      z_ch  <= '0;
      z     <= 1'b0;
      z_vec <= '0;
    end else begin
      z_vld <= found;
      if (found) begin
        ctx[win]   <= ctx_upd;
        ptr        <= ptr_nxt;
        z_ch       <= win;
        z          <= ctx_out(ctx_upd);
        z_vec[win] <= ctx_out(ctx_upd);
      end
`ifdef Q3B_CTX_CLR_EN
      // A cleared channel is masked from arbitration, so it never collides with the winner
      for (int i = 0; i < N_CH; i++) begin
        if (ch_clr[i]) begin
          ctx[i]   <= CTX_A;
          z_vec[i] <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_q3b_ctx_scheduler.sv
// tb/tb_q3b_ctx_scheduler.sv - directed + randomized bench for q3b_ctx_scheduler against a behavioural model
module tb_q3b_ctx_scheduler;
  localparam int N  = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req = '0;
  logic [N-1:0]  x = '0;
  logic [N-1:0]  gnt;
  logic          z_vld;
  logic [IW-1:0] z_ch;
  logic          z;
  logic [N-1:0]  z_vec;
  logic [N-1:0]  clr_v;
`ifdef Q3B_CTX_CLR_EN
  logic [N-1:0]  ch_clr = '0;
  assign clr_v = ch_clr;
`else
  assign clr_v = '0;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  q3b_ctx_scheduler #(.N_CH(N)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .x     (x),
`ifdef Q3B_CTX_CLR_EN
    .ch_clr(ch_clr),
`endif
    .gnt   (gnt),
    .z_vld (z_vld),
    .z_ch  (z_ch),
    .z     (z),
    .z_vec (z_vec)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: state table indexed [state][bit], states A..E = 0..4
  int nxt_tab [5][2] = '{'{0, 1}, '{1, 4}, '{2, 1}, '{1, 2}, '{3, 4}};
  int           m_ctx [N];
  int           m_ptr = 0;
  bit           m_vld = 0;
  int           m_ch = 0;
  bit           m_z = 0;
  logic [N-1:0] m_vec = '0;
  int           m_last = -1;
  int           m_w;
  int           waitc [N];

  function automatic bit det(input int c);
    return (c == 3) || (c == 4);
  endfunction

  function automatic int pick();
    int c;
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (req[c] && !clr_v[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) m_ctx[i] = 0;
      m_ptr = 0; m_vld = 0; m_ch = 0; m_z = 0; m_vec = '0; m_last = -1;
    end else begin
      m_w = pick();
      m_last = m_w;
      m_vld = (m_w >= 0);
      for (int i = 0; i < N; i++) begin
        if (clr_v[i]) begin
          m_ctx[i] = 0;
          m_vec[i] = 1'b0;
        end
      end
      if (m_w >= 0) begin
        m_ctx[m_w] = nxt_tab[m_ctx[m_w]][x[m_w]];
        m_ptr = (m_w + 1) % N;
        m_ch = m_w;
        m_z = det(m_ctx[m_w]);
        m_vec[m_w] = m_z;
      end
    end
  end

  // Compare process: every falling edge, registered outputs and grant versus the model
  always @(negedge clk) begin
    chk("z_vld", z_vld, m_vld);
    chk("z_ch", z_ch, m_ch);
    chk("z", z, m_z);
    chk("z_vec", z_vec, m_vec);
    if (!reset) begin
      chk("gnt", gnt, (pick() >= 0) ? (1 << pick()) : 0);
      for (int i = 0; i < N; i++) begin
        if (req[i] && !clr_v[i] && !gnt[i]) waitc[i]++;
        else waitc[i] = 0;
        chk("fair", waitc[i] < N, 1);
      end
    end else begin
      for (int i = 0; i < N; i++) waitc[i] = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [N-1:0] r, input logic [N-1:0] xv);
    req = r;
    x = xv;
  endtask

  task automatic do_reset();
    set_in('0, '0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] xv;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    tick();
    tick();
    chk("rst_z_vld", z_vld, 0);
    chk("rst_z_ch", z_ch, 0);
    chk("rst_z", z, 0);
    chk("rst_z_vec", z_vec, 0);
    reset = 1'b0;

    // 1: ch0 x=1,1,0 -> B,E,D
    set_in(4'b0001, 4'b0001); #1;
    chk("t1_gnt", gnt, 4'b0001);
    tick();
    chk("t1_vld0", z_vld, 1); chk("t1_ch0", z_ch, 0); chk("t1_z0", z, 0);
    tick();
    chk("t1_z1", z, 1);
    set_in(4'b0001, 4'b0000);
    tick();
    chk("t1_z2", z, 1); chk("t1_vec", z_vec[0], 1);
    set_in('0, '0);
    tick();
    chk("t1_idle_vld", z_vld, 0); chk("t1_idle_z", z, 1);

    // 2: all requesting, rotation from ptr=0
    do_reset();
    set_in(4'b1111, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t2_gnt", gnt, 1 << (k % 4));
      tick();
      chk("t2_z_ch", z_ch, k % 4);
    end

    // 3: ch1 x=1 interleaved with ch2 x=0
    do_reset();
    set_in(4'b0110, 4'b0010);
    tick(); tick(); tick();
    chk("t3_vec", z_vec, 4'b0010); chk("t3_ch", z_ch, 1); chk("t3_z", z, 1);

    // 4: ch3 to D then 1,1 -> C,B
    do_reset();
    set_in(4'b1000, 4'b1000);
    tick(); tick();
    set_in(4'b1000, 4'b0000);
    tick();
    chk("t4_vecD", z_vec, 4'b1000);
    set_in(4'b1000, 4'b1000);
    tick();
    chk("t4_zC", z, 0); chk("t4_vecC", z_vec, 4'b0000);
    tick();
    chk("t4_zB", z, 0); chk("t4_chB", z_ch, 3);

    // 5: async reset mid-burst with ch0 in E
    do_reset();
    set_in(4'b0001, 4'b0001);
    tick(); tick();
    chk("t5_vecE", z_vec, 4'b0001);
    set_in(4'b0101, 4'b0101);
    #2 reset = 1'b1;
    #1;
    chk("t5_vld", z_vld, 0); chk("t5_z", z, 0); chk("t5_vec", z_vec, 0); chk("t5_ch", z_ch, 0);
    #2 reset = 1'b0;
    #1;
    chk("t5_gnt", gnt, 4'b0001);
    tick();
    chk("t5_rvld", z_vld, 1); chk("t5_rch", z_ch, 0); chk("t5_rz", z, 0);

`ifdef Q3B_CTX_CLR_EN
    // 6: clear ch0 (in E) while it and ch1 request
    do_reset();
    set_in(4'b0001, 4'b0001);
    tick(); tick();
    set_in(4'b0011, 4'b0011);
    ch_clr = 4'b0001;
    #1;
    chk("t6_gnt", gnt, 4'b0010);
    tick();
    ch_clr = '0;
    chk("t6_vec", z_vec, 4'b0000); chk("t6_ch", z_ch, 1);
    set_in(4'b0001, 4'b0001);
    tick();
    chk("t6_restart", z, 0);
`endif

    // Randomized phase: requests held until granted, occasional early drop and idle
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      r = req;
      xv = x;
      if (m_last >= 0) r[m_last] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!r[i]) begin
          xv[i] = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 2) != 0) r[i] = 1'b1;
        end else if ($urandom_range(0, 31) == 0) begin
          r[i] = 1'b0;
        end
      end
      if (n % 97 == 0) r = '0;
`ifdef Q3B_CTX_CLR_EN
      ch_clr = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '0;
`endif
      set_in(r, xv);
      tick();
    end
    set_in('0, '0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
